// File: rtl/score_keeper.sv
// score_keeper: turns two debounced push-button channels into per-player
// points, keeps the scores and detects the end of a game.
// Build option: define HOLD_RESTART_EN to let "both buttons held" in OVER
// restart the game exactly like new_game; undefined, only new_game restarts.
module score_keeper #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned MAX_SCORE       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn,
  input  logic       new_game,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] point_pulse,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned SCORE_W = 4;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MAX_S    = SCORE_W'(MAX_SCORE);

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  state_t             state;
  logic [1:0]         s1;
  logic [1:0]         s2;
  logic [1:0]         stable;
  logic [1:0]         stable_d;
  logic [CNT_W-1:0]   cnt [2];

  logic [1:0]         rise_c;
  logic [SCORE_W-1:0] p1_inc_c;
  logic [SCORE_W-1:0] p2_inc_c;
  logic [1:0]         reach_c;
  logic               restart_c;

  // Two-flop synchronizer for both button channels
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
      stable <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed copy of the stable levels for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  // Press events, saturating score increments and restart request
  always_comb begin
    rise_c   = stable & ~stable_d;
    p1_inc_c = score_p1;
    p2_inc_c = score_p2;
    if (rise_c[0] && (score_p1 < MAX_S)) begin
      p1_inc_c = score_p1 + SCORE_W'(1);
    end
    if (rise_c[1] && (score_p2 < MAX_S)) begin
      p2_inc_c = score_p2 + SCORE_W'(1);
    end
    reach_c   = {(p2_inc_c == MAX_S), (p1_inc_c == MAX_S)};
    restart_c = new_game;
`ifdef HOLD_RESTART_EN
    if ((state == OVER) && (stable == 2'b11)) begin
      restart_c = 1'b1;
    end
`else
`endif
  end

  // Game FSM with registered scores, strobes and end-of-game flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PLAY;
      score_p1    <= '0;
      score_p2    <= '0;
      point_pulse <= '0;
      game_over   <= 1'b0;
      winner      <= '0;
    end else begin
      point_pulse <= '0;
      case (state)
        PLAY: begin
          if (restart_c) begin
            score_p1 <= '0;
            score_p2 <= '0;
          end else begin
            point_pulse <= rise_c;
            score_p1    <= p1_inc_c;
            score_p2    <= p2_inc_c;
            if (|reach_c) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= reach_c;
            end
          end
        end
        OVER: begin
          if (restart_c) begin
            state     <= PLAY;
            score_p1  <= '0;
            score_p2  <= '0;
            game_over <= 1'b0;
            winner    <= '0;
          end
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper with DEBOUNCE_CYCLES=4, MAX_SCORE=3.
module tb_score_keeper;

  localparam int DC   = 4;
  localparam int MAXS = 3;
`ifdef HOLD_RESTART_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] btn;
  logic       new_game;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] point_pulse;
  logic       game_over;
  logic [1:0] winner;

  int total = 0;
  int bad   = 0;

  score_keeper #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(3),
    .MAX_SCORE(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .new_game(new_game),
    .score_p1(score_p1),
    .score_p2(score_p2),
    .point_pulse(point_pulse),
    .game_over(game_over),
    .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button level counts once the synchronized samples
  // (btn as seen two edges earlier) agree on a new value for DC edges in a row.
  bit       hist [2][DC+1];
  bit [1:0] m_stable;
  bit [1:0] m_rise;
  int       m_s1, m_s2;
  bit [1:0] m_pulse;
  bit       m_over;
  bit [1:0] m_win;
  bit       m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++)
        for (int j = 0; j <= DC; j++) hist[c][j] = 1'b0;
      m_stable = '0; m_rise = '0; m_s1 = 0; m_s2 = 0;
      m_pulse = '0; m_over = 1'b0; m_win = '0; m_valid = 1'b1;
    end else begin
      m_pulse = '0;
      if (!m_over) begin
        if (new_game) begin
          m_s1 = 0; m_s2 = 0;
        end else begin
          if (m_rise[0]) begin m_pulse[0] = 1'b1; if (m_s1 < MAXS) m_s1++; end
          if (m_rise[1]) begin m_pulse[1] = 1'b1; if (m_s2 < MAXS) m_s2++; end
          if (m_s1 == MAXS || m_s2 == MAXS) begin
            m_over = 1'b1;
            m_win  = {m_s2 == MAXS, m_s1 == MAXS};
          end
        end
      end else if (new_game || (HOLD && m_stable == 2'b11)) begin
        m_over = 1'b0; m_win = '0; m_s1 = 0; m_s2 = 0;
      end
      for (int c = 0; c < 2; c++) begin
        bit same;
        same = (hist[c][1] != m_stable[c]);
        for (int j = 2; j <= DC; j++) if (hist[c][j] != hist[c][1]) same = 1'b0;
        m_rise[c] = 1'b0;
        if (same) begin
          m_stable[c] = hist[c][1];
          m_rise[c]   = hist[c][1];
        end
        for (int j = DC; j >= 1; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = btn[c];
      end
    end
  end

  // Scoreboard compare on every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (m_valid)
      check("outputs",
            16'({score_p1, score_p2, point_pulse, game_over, winner}),
            16'({4'(m_s1), 4'(m_s2), m_pulse, m_over, m_win}));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] b);
    btn = b;
    tick(9);
    btn = 2'b00;
    tick(12);
  endtask

  initial begin
    rst = 1'b1; btn = 2'b00; new_game = 1'b0;
    tick(2);
    check("reset_out", 16'({score_p1, score_p2, point_pulse, game_over, winner}), 16'(0));
    rst = 1'b0;

    btn = 2'b01;
    tick(6); check("p1_early", 16'(point_pulse), 16'(0));
    tick(1); check("p1_pulse", 16'(point_pulse), 16'(1));
    check("p1_score", 16'({score_p1, score_p2}), 16'(8'h10));
    tick(1); check("p1_once", 16'(point_pulse), 16'(0));
    tick(2); btn = 2'b00; tick(12);

    btn = 2'b10; tick(3); btn = 2'b00; tick(12);
    check("glitch3", 16'(score_p2), 16'(0));
    btn = 2'b10; tick(4); btn = 2'b00; tick(12);
    check("pulse4", 16'(score_p2), 16'(1));

    press(2'b10); press(2'b10);
    check("p2_score3", 16'(score_p2), 16'(3));
    check("p2_over", 16'({game_over, winner}), 16'(3'b110));
    press(2'b10);
    check("p2_sat", 16'(score_p2), 16'(3));

    btn = 2'b01; tick(10);
    check("over_ignore", 16'(score_p1), 16'(1));
    new_game = 1'b1; tick(1); new_game = 1'b0;
    check("restart_clr", 16'({score_p1, score_p2, game_over, winner}), 16'(0));
    tick(10);
    check("held_nopt", 16'(score_p1), 16'(0));
    btn = 2'b00; tick(12);
    press(2'b01);
    check("fresh_press", 16'(score_p1), 16'(1));

    press(2'b01); press(2'b10); press(2'b10);
    check("tie_setup", 16'({score_p1, score_p2}), 16'(8'h22));
    btn = 2'b11; tick(7);
    check("both_pulse", 16'(point_pulse), 16'(3));
    check("both_score", 16'({score_p1, score_p2}), 16'(8'h33));
    check("draw", 16'({game_over, winner}), 16'(3'b111));
    tick(2); btn = 2'b00; tick(12);
    new_game = 1'b1; tick(1); new_game = 1'b0;

    btn = 2'b01; tick(2);
    rst = 1'b1; tick(2);
    check("rst_mid", 16'({score_p1, score_p2, point_pulse, game_over, winner}), 16'(0));
    rst = 1'b0;
    tick(6); check("rst_early", 16'(point_pulse), 16'(0));
    tick(1); check("rst_pulse", 16'(point_pulse), 16'(1));
    check("rst_score", 16'(score_p1), 16'(1));
    btn = 2'b00; tick(12);

    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
      new_game = ($urandom_range(0, 79) == 0);
      rst      = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rst = 1'b0; new_game = 1'b0; btn = 2'b00;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits directly downstream of the breadboard button-conditioning stage.
- Consumes its two registered, active-high button levels and turns each clean press into a single point for the matching player.
- Keeps per-player scores and detects the end of a game.
- Outputs drive the score display and the game-control logic of the pong design.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles an input must hold a new level before it is accepted (10 ms at 100 MHz); legal range >= 2
CNT_W, 20, debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
MAX_SCORE, 9, score that ends the game; legal range 1..15

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
btn  input  2  button levels, active-high; bit0 = player 1, bit1 = player 2
new_game  input  1  single-cycle request: clear scores and return to PLAY
score_p1  output  4  player 1 score, 0..MAX_SCORE
score_p2  output  4  player 2 score, 0..MAX_SCORE
point_pulse  output  2  one-cycle strobe per accepted point; bit0 = p1, bit1 = p2
game_over  output  1  high while in OVER
winner  output  2  01 = p1, 10 = p2, 11 = draw, 00 = none

Behaviour:
- Reset: one clock, synchronous, active-high on rst.
  - All outputs are 0.
  - Synchronizers, stable levels and counters are cleared.
  - State is PLAY.
  - rst asserted mid-debounce or mid-game discards everything. The first press after reset requires a full debounce.
- Per-channel input conditioning, channels independent:
  - 2-flop synchronizer: btn -> s1 -> s2.
  - Debounce:
    - Each edge where s2 != stable: cnt increments.
    - When cnt == DEBOUNCE_CYCLES-1 and s2 still != stable: stable <= s2 and cnt <= 0.
    - Any edge with s2 == stable: cnt <= 0. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
  - Rising edge of stable (0->1) produces an internal event. Falling edges produce nothing.
  - Latency: btn rising step to point_pulse high = DEBOUNCE_CYCLES+3 edges, exactly.
- States: PLAY, OVER.
- PLAY:
  - An event on channel i produces point_pulse[i] = 1 for exactly one cycle.
  - The matching score increments on the same edge that raises the pulse.
  - Both channels firing in the same cycle: both pulses assert and both scores increment.
  - When the updated score(s) reach MAX_SCORE, the FSM enters OVER on that same edge and sets game_over = 1.
  - winner: 01 or 10 for the single player who reached MAX_SCORE; 11 if both reach it on the same edge.
  - Scores saturate at MAX_SCORE and never wrap.
- OVER:
  - Events are ignored: no pulses, no score change.
  - game_over and winner stay held.
  - new_game = 1 returns to PLAY on the next edge with scores, winner and game_over cleared.
- new_game in PLAY: clears both scores. An event in the same cycle is dropped; new_game has priority.
- Debounce keeps running in every state. A button held through a restart does not create a point; a fresh rising edge is required.

Optional Feature:
HOLD_RESTART_EN
- Defined: in OVER, if both stable levels are 1 simultaneously for one cycle, the block behaves exactly as if new_game were asserted. The held buttons do not score after restart because no rising edge occurs.
- Undefined: only new_game leaves OVER; the hold-both gesture has no effect.

Test Plan:
All runs use DEBOUNCE_CYCLES=4, MAX_SCORE=3.
- Reset, then btn=01 step held 10 cycles -> point_pulse=01 for exactly 1 cycle, 7 edges after the step; score_p1=1, score_p2=0.
- btn[1] glitch high for 3 cycles, then low -> no point_pulse; score_p2 stays 0. Repeat with a 4-cycle pulse -> score_p2=1.
- Three clean p2 presses -> score_p2=3, game_over=1, winner=10. A fourth press -> no pulse, score_p2 stays 3.
- Scores 2:2, both buttons rise on the same cycle -> point_pulse=11, scores 3:3, winner=11, game_over=1.
- In OVER, assert new_game for 1 cycle -> next edge: scores 0:0, game_over=0, winner=00. Button held throughout gives no point until released and pressed again.
- rst pulsed 2 cycles into a debounce -> outputs 0; release rst with btn held -> a point arrives 7 edges later. With HOLD_RESTART_EN: both buttons held in OVER -> restart with no pulse.
